// File: rtl/wb_stage_if.sv
// Writeback stage bus: execute-side record handshake, data-memory read channel,
// and the GPR/CSR write ports plus commit/retire outputs.
interface wb_stage_if #(parameter int CNT_W = 64);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_rd;
   logic             in_rd_wen;
   logic [31:0]      in_alu_res;
   logic             in_is_load;
   logic [2:0]       in_ld_fmt;
   logic [1:0]       in_addr_lo;
   logic [1:0]       in_csr_rd;
   logic             in_csr_wen;
   logic [31:0]      in_csr_wd;
   logic             in_ecall;
   logic [31:0]      in_pc_next;
   logic             mem_rvalid;
   logic [31:0]      mem_rdata;
   logic             mem_rready;
   logic [4:0]       rd;
   logic [31:0]      wd;
   logic             rwEnable;
   logic [1:0]       csr_rd;
   logic [31:0]      csr_wd;
   logic             csrwEnable;
   logic             ecall;
   logic             commit_valid;
   logic [31:0]      commit_pc;
   logic             bus_err;
   logic [CNT_W-1:0] instret;

   modport master (
      output in_valid, in_rd, in_rd_wen, in_alu_res, in_is_load, in_ld_fmt, in_addr_lo,
             in_csr_rd, in_csr_wen, in_csr_wd, in_ecall, in_pc_next, mem_rvalid, mem_rdata,
      input  in_ready, mem_rready, rd, wd, rwEnable, csr_rd, csr_wd, csrwEnable, ecall,
             commit_valid, commit_pc, bus_err, instret
   );

   modport slave (
      input  in_valid, in_rd, in_rd_wen, in_alu_res, in_is_load, in_ld_fmt, in_addr_lo,
             in_csr_rd, in_csr_wen, in_csr_wd, in_ecall, in_pc_next, mem_rvalid, mem_rdata,
      output in_ready, mem_rready, rd, wd, rwEnable, csr_rd, csr_wd, csrwEnable, ecall,
             commit_valid, commit_pc, bus_err, instret
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: latches one retired record, optionally waits for load data,
// then issues a single-cycle GPR/CSR write, commit pulse and instret increment.
module wb_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 64
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

   state_t           state, state_nx;
   logic [TW-1:0]    tcnt;
   logic             timed_out;
   logic [4:0]       rd_q;
   logic             rd_wen_q;
   logic [31:0]      wd_q;
   logic [2:0]       fmt_q;
   logic [1:0]       lo_q;
   logic [1:0]       csr_rd_q;
   logic             csr_wen_q;
   logic [31:0]      csr_wd_q;
   logic             ecall_q;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] instret_q;
   logic             accept;
   logic             tmo_hit;

   function automatic logic [31:0] fmt_load(input logic [2:0] fmt, input logic [1:0] lo,
                                            input logic [31:0] data);
      logic [31:0] w;
      w = data >> {lo, 3'b000};
      case (fmt)
         3'b000:  fmt_load = {{24{w[7]}}, w[7:0]};
         3'b100:  fmt_load = {24'h0, w[7:0]};
         3'b001:  fmt_load = {{16{w[15]}}, w[15:0]};
         3'b101:  fmt_load = {16'h0, w[15:0]};
         default: fmt_load = data;
      endcase
   endfunction

   assign accept  = (state == IDLE) && bus.in_valid;
   // Load data arriving on the final wait cycle takes priority over the timeout.
   assign tmo_hit = (TIMEOUT > 0) && (state == WAIT_MEM) && !bus.mem_rvalid &&
                    (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx         = state;
      bus.in_ready     = 1'b0;
      bus.mem_rready   = 1'b0;
      bus.commit_valid = 1'b0;
      bus.rwEnable     = 1'b0;
      bus.csrwEnable   = 1'b0;
      bus.ecall        = 1'b0;
      bus.bus_err      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = bus.in_is_load ? WAIT_MEM : COMMIT;
         end
         WAIT_MEM: begin
            bus.mem_rready = 1'b1;
            if (bus.mem_rvalid || tmo_hit) state_nx = COMMIT;
         end
         COMMIT: begin
            bus.commit_valid = 1'b1;
            bus.rwEnable     = rd_wen_q && (rd_q != 5'd0) && !timed_out;
            bus.csrwEnable   = csr_wen_q;
            bus.ecall        = ecall_q;
            bus.bus_err      = timed_out;
            state_nx         = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt      <= '0;
         timed_out <= 1'b0;
         rd_q      <= '0;
         rd_wen_q  <= 1'b0;
         wd_q      <= '0;
         fmt_q     <= '0;
         lo_q      <= '0;
         csr_rd_q  <= '0;
         csr_wen_q <= 1'b0;
         csr_wd_q  <= '0;
         ecall_q   <= 1'b0;
         pc_q      <= '0;
         instret_q <= '0;
      end else begin
         if (accept) begin
            rd_q      <= bus.in_rd;
            rd_wen_q  <= bus.in_rd_wen;
            wd_q      <= bus.in_alu_res;
            fmt_q     <= bus.in_ld_fmt;
            lo_q      <= bus.in_addr_lo;
            csr_rd_q  <= bus.in_csr_rd;
            csr_wen_q <= bus.in_csr_wen;
            csr_wd_q  <= bus.in_csr_wd;
            ecall_q   <= bus.in_ecall;
            pc_q      <= bus.in_pc_next;
            timed_out <= 1'b0;
            tcnt      <= '0;
         end
         if (state == WAIT_MEM) begin
            if (bus.mem_rvalid) begin
               wd_q <= fmt_load(fmt_q, lo_q, bus.mem_rdata);
               tcnt <= '0;
            end else if (tmo_hit) begin
               timed_out <= 1'b1;
               tcnt      <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
         // Count on entry so instret already reflects this retire during the commit pulse.
         if (state_nx == COMMIT) instret_q <= instret_q + 1'b1;
      end
   end

   assign bus.rd        = rd_q;
   assign bus.wd        = wd_q;
   assign bus.csr_rd    = csr_rd_q;
   assign bus.csr_wd    = csr_wd_q;
   assign bus.commit_pc = pc_q;
   assign bus.instret   = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage: a transaction-level model predicts every cycle's
// handshake, pulse and write-port values; one negedge process compares them.
module tb_wb_stage;
   localparam int TMO = 16;

   typedef struct {
      logic [4:0]  rd;
      logic        rd_wen;
      logic [31:0] alu;
      logic        is_load;
      logic [2:0]  fmt;
      logic [1:0]  lo;
      logic [1:0]  csr_rd;
      logic        csr_wen;
      logic [31:0] csr_wd;
      logic        ecall;
      logic [31:0] pc;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_stage_if #(.CNT_W(64)) bus ();
   wb_stage #(.TIMEOUT(TMO), .CNT_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   logic [63:0] exp_cnt = 64'd0;

   logic        e_in_ready, e_mem_rready, e_commit, e_rwen, e_csrwen, e_ecall, e_buserr;
   logic [4:0]  e_rd;
   logic [31:0] e_wd, e_csr_wd, e_pc;
   logic [1:0]  e_csr_rd;
   logic [63:0] e_instret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference load formatting from plain integer arithmetic.
   function automatic logic [31:0] model_fmt(input logic [2:0] f, input logic [1:0] lo,
                                             input logic [31:0] d);
      longint w, v;
      int n;
      w = longint'(d) >> (8 * int'(lo));
      if (f == 3'b000 || f == 3'b100)      n = 8;
      else if (f == 3'b001 || f == 3'b101) n = 16;
      else return d;
      v = w % (longint'(1) << n);
      if (!f[2] && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
      return 32'(v);
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready", bus.in_ready, e_in_ready);
         chk("mem_rready", bus.mem_rready, e_mem_rready);
         chk("commit_valid", bus.commit_valid, e_commit);
         chk("rwEnable", bus.rwEnable, e_rwen);
         chk("csrwEnable", bus.csrwEnable, e_csrwen);
         chk("ecall", bus.ecall, e_ecall);
         chk("bus_err", bus.bus_err, e_buserr);
         chk("instret", bus.instret, e_instret);
         if (e_rwen) begin
            chk("rd", bus.rd, e_rd);
            chk("wd", bus.wd, e_wd);
         end
         if (e_csrwen) begin
            chk("csr_rd", bus.csr_rd, e_csr_rd);
            chk("csr_wd", bus.csr_wd, e_csr_wd);
         end
         if (e_commit) chk("commit_pc", bus.commit_pc, e_pc);
      end
   end

   task automatic set_idle_exp();
      e_in_ready = 1'b1; e_mem_rready = 1'b0; e_commit = 1'b0; e_rwen = 1'b0;
      e_csrwen = 1'b0; e_ecall = 1'b0; e_buserr = 1'b0; e_instret = exp_cnt;
   endtask

   // Advance one cycle; inputs not driven deliberately get random junk.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      set_idle_exp();
      bus.in_valid   = 1'b0;
      bus.in_rd      = 5'($urandom);
      bus.in_rd_wen  = 1'($urandom);
      bus.in_alu_res = $urandom;
      bus.in_is_load = 1'($urandom);
      bus.in_ld_fmt  = 3'($urandom);
      bus.in_addr_lo = 2'($urandom);
      bus.in_csr_rd  = 2'($urandom);
      bus.in_csr_wen = 1'($urandom);
      bus.in_csr_wd  = $urandom;
      bus.in_ecall   = 1'($urandom);
      bus.in_pc_next = $urandom;
      bus.mem_rvalid = 1'($urandom);
      bus.mem_rdata  = $urandom;
   endtask

   task automatic drive_rec(input rec_t r);
      bus.in_valid   = 1'b1;
      bus.in_rd      = r.rd;
      bus.in_rd_wen  = r.rd_wen;
      bus.in_alu_res = r.alu;
      bus.in_is_load = r.is_load;
      bus.in_ld_fmt  = r.fmt;
      bus.in_addr_lo = r.lo;
      bus.in_csr_rd  = r.csr_rd;
      bus.in_csr_wen = r.csr_wen;
      bus.in_csr_wd  = r.csr_wd;
      bus.in_ecall   = r.ecall;
      bus.in_pc_next = r.pc;
   endtask

   // dly = wait cycles before rvalid; dly >= TMO means memory never answers.
   task automatic run_tx(input rec_t r, input int dly, input logic [31:0] rdata);
      logic        tmo;
      logic [31:0] wdv;
      tmo = 1'b0;
      wdv = r.alu;
      next_cycle();
      drive_rec(r);
      if (r.is_load) begin
         tmo = (dly >= TMO);
         for (int k = 0; k < TMO; k++) begin
            next_cycle();
            e_in_ready = 1'b0; e_mem_rready = 1'b1;
            bus.in_valid = 1'($urandom);
            if (k == dly) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = rdata;
               wdv = model_fmt(r.fmt, r.lo, rdata);
               break;
            end
            bus.mem_rvalid = 1'b0;
         end
      end
      next_cycle();
      bus.in_valid = 1'($urandom);
      exp_cnt   = exp_cnt + 64'd1;
      e_in_ready = 1'b0; e_commit = 1'b1;
      e_rwen    = r.rd_wen && (r.rd != 5'd0) && !tmo;
      e_rd      = r.rd;  e_wd = wdv;
      e_csrwen  = r.csr_wen; e_csr_rd = r.csr_rd; e_csr_wd = r.csr_wd;
      e_ecall   = r.ecall; e_buserr = tmo; e_pc = r.pc; e_instret = exp_cnt;
   endtask

   function automatic rec_t mk(input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                               input logic ld, input logic [2:0] fmt, input logic [1:0] lo);
      rec_t r;
      r.rd = rd; r.rd_wen = wen; r.alu = alu; r.is_load = ld; r.fmt = fmt; r.lo = lo;
      r.csr_rd = 2'd0; r.csr_wen = 1'b0; r.csr_wd = 32'h0; r.ecall = 1'b0;
      r.pc = 32'h1000 + 32'(rd) * 4;
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rec_t r;
      bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_rd_wen = 1'b0; bus.in_alu_res = '0;
      bus.in_is_load = 1'b0; bus.in_ld_fmt = '0; bus.in_addr_lo = '0; bus.in_csr_rd = '0;
      bus.in_csr_wen = 1'b0; bus.in_csr_wd = '0; bus.in_ecall = 1'b0; bus.in_pc_next = '0;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      set_idle_exp();
      chk_on = 1'b1;

      // Model anchors computed by hand.
      chk("model_lb", model_fmt(3'b000, 2'd2, 32'h0080_0000), 32'hFFFF_FF80);
      chk("model_lhu", model_fmt(3'b101, 2'd0, 32'hABCD_8001), 32'h0000_8001);
      chk("model_lw", model_fmt(3'b010, 2'd0, 32'hABCD_8001), 32'hABCD_8001);
      chk("model_lh_mis", model_fmt(3'b001, 2'd3, 32'hF100_0000), 32'h0000_00F1);
      chk("model_lbu", model_fmt(3'b100, 2'd1, 32'h0000_9A00), 32'h0000_009A);

      repeat (2) next_cycle();
      #2;
      chk("rst_rd", bus.rd, 0);
      chk("rst_wd", bus.wd, 0);
      chk("rst_csr_rd", bus.csr_rd, 0);
      chk("rst_csr_wd", bus.csr_wd, 0);
      chk("rst_commit_pc", bus.commit_pc, 0);
      next_cycle();
      rst = 1'b1;

      run_tx(mk(5'd5, 1'b1, 32'h0000_1234, 1'b0, 3'b000, 2'd0), 0, 32'h0);
      run_tx(mk(5'd6, 1'b1, 32'hDEAD_0000, 1'b1, 3'b000, 2'd2), 3, 32'h0080_0000);
      run_tx(mk(5'd7, 1'b1, 32'h0, 1'b1, 3'b101, 2'd0), 0, 32'hABCD_8001);
      run_tx(mk(5'd8, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0), 1, 32'hABCD_8001);
      run_tx(mk(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'b000, 2'd0), 0, 32'h0);
      run_tx(mk(5'd9, 1'b1, 32'h0, 1'b1, 3'b000, 2'd0), TMO, 32'h0);
      run_tx(mk(5'd10, 1'b1, 32'h0, 1'b1, 3'b001, 2'd1), TMO - 1, 32'h00F0_8000);
      r = mk(5'd11, 1'b1, 32'h55AA_55AA, 1'b0, 3'b000, 2'd0);
      r.csr_wen = 1'b1; r.csr_rd = 2'd1; r.csr_wd = 32'hCAFE_F00D; r.ecall = 1'b1;
      run_tx(r, 0, 32'h0);

      // Reset in the middle of a load; the late memory response must be ignored.
      next_cycle();
      drive_rec(mk(5'd12, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0));
      repeat (3) begin
         next_cycle();
         e_in_ready = 1'b0; e_mem_rready = 1'b1; bus.mem_rvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0; exp_cnt = 64'd0; bus.mem_rvalid = 1'b0; bus.in_valid = 1'b0;
      set_idle_exp();
      #1;
      chk("arst_in_ready", bus.in_ready, 1);
      chk("arst_mem_rready", bus.mem_rready, 0);
      chk("arst_instret", bus.instret, 0);
      next_cycle();
      bus.mem_rvalid = 1'b1;
      next_cycle();
      rst = 1'b1; bus.mem_rvalid = 1'b1;
      next_cycle();
      bus.mem_rvalid = 1'b1;
      run_tx(mk(5'd13, 1'b1, 32'h0000_0BAD, 1'b0, 3'b000, 2'd0), 0, 32'h0);

      for (int i = 0; i < 300; i++) begin
         r.rd = 5'($urandom); r.rd_wen = 1'($urandom); r.alu = $urandom;
         r.is_load = 1'($urandom); r.fmt = 3'($urandom); r.lo = 2'($urandom);
         r.csr_rd = 2'($urandom); r.csr_wen = 1'($urandom); r.csr_wd = $urandom;
         r.ecall = 1'($urandom); r.pc = $urandom;
         repeat ($urandom_range(0, 2)) next_cycle();
         run_tx(r, int'($urandom_range(0, 18)), $urandom);
      end
      next_cycle();
      next_cycle();
      @(posedge clk);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
